boot_sequencer: RTL and testbench
=================================

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 Parameters SHALL be:
- LOAD_CYCLES, default 1: cycles file-load strobes are held (legal 1-255).
- RUN_LIMIT, default 3334: maximum RUN cycles; 0 means unlimited.
- CW, default 16: width of cycle counter.
REQ-002 CLK  in  1  single clock; all state changes on rising edge.
REQ-003 RESET_N  in  1  reset, asynchronous and active-low.
REQ-004 start  in  1  begin boot sequence; sampled only in IDLE or DONE.
REQ-005 halt_req  in  1  processor requests stop; sampled only in RUN.
REQ-006 im_RESET, dm_RESET  out  1 each  instruction/data memory reset.
REQ-007 im_read_file, dm_read_file  out  1 each  memory image load strobes.
REQ-008 im_write_file, dm_write_file  out  1 each  memory image dump strobes.
REQ-009 pc_RESET, rb_RESET, tf_RESET, rf_RESET  out  1 each  core datapath resets.
REQ-010 uc_RESET  out  1  control unit reset.
REQ-011 run  out  1  processor enable; high only in RUN.
REQ-012 done  out  1  sequence complete; high only in DONE.
REQ-013 timeout  out  1  RUN ended by RUN_LIMIT rather than halt_req.
REQ-014 cyc_count  out  CW  number of RUN cycles of the current or last run.
REQ-015 state  out  3  encoded FSM state for debug.

Function
REQ-016 FSM states SHALL be IDLE=0, MEM_RST=1, LOAD=2, CORE_RST=3, UC_RST=4, RUN=5, DUMP=6, DONE=7.
REQ-017 All outputs SHALL be registered or decoded purely from registered state and counters (Moore); no input-to-output combinational path.
REQ-018 IDLE: start=1 -> MEM_RST next edge; otherwise stay.
REQ-019 MEM_RST SHALL last exactly 1 cycle, then go to LOAD.
REQ-020 LOAD SHALL last exactly LOAD_CYCLES cycles (internal 8-bit down-counter), then go to CORE_RST.
REQ-021 CORE_RST SHALL last 1 cycle, then go to UC_RST.
REQ-022 UC_RST SHALL last 1 cycle, then go to RUN.
REQ-023 RUN SHALL exit to DUMP on the edge where halt_req=1 is sampled, or after the RUN_LIMIT-th RUN cycle when RUN_LIMIT!=0.
REQ-024 DUMP SHALL last 1 cycle, then go to DONE.
REQ-025 DONE: start=1 -> MEM_RST (full re-boot); otherwise stay.
REQ-026 Output decode by state:
- MEM_RST: im_RESET=dm_RESET=1.
- LOAD: im_read_file=dm_read_file=1.
- DUMP: im_write_file=dm_write_file=1.
- These six SHALL be 0 in all other states.
REQ-027 pc/rb/tf/rf_RESET SHALL be 1 in IDLE, MEM_RST, LOAD and CORE_RST, and 0 otherwise.
REQ-028 uc_RESET SHALL be 1 in IDLE through UC_RST, and 0 otherwise.
REQ-029 cyc_count behaviour:
- cleared to 0 on entry to RUN.
- increments by 1 every RUN cycle.
- saturates at all-ones, no wrap.
- holds its value in DUMP, DONE and IDLE.
REQ-030 timeout SHALL be set on a limit-caused exit from RUN, cleared on entry to MEM_RST, and otherwise held.
REQ-031 If halt_req=1 and the limit is reached in the same cycle, halt SHALL take priority and timeout SHALL remain 0.
REQ-032 start SHALL be ignored in states MEM_RST through DUMP; halt_req SHALL be ignored outside RUN.
REQ-033 The RUN_LIMIT compare SHALL use a counter independent of CW saturation so that any RUN_LIMIT below 2^CW is exact.

Reset
REQ-034 RESET_N=0 SHALL immediately (asynchronously) force:
- state=IDLE, cyc_count=0, timeout=0, load counter=0.
- outputs per IDLE decode: core resets=1, uc_RESET=1, all others 0.
REQ-035 Reset asserted mid-sequence, including during LOAD or DUMP, SHALL drop the file strobes the same instant; no partial sequence resumes after release.
REQ-036 After RESET_N rises, the first edge SHALL evaluate IDLE transitions normally.

Verification
REQ-037 Nominal boot: LOAD_CYCLES=1, RUN_LIMIT=0, start pulse, then halt_req at RUN cycle 10.
- Response: state 1,2,3,4,5 on consecutive edges; run high exactly 10 cycles; DUMP 1 cycle; done=1; cyc_count=10; timeout=0.
REQ-038 Watchdog: RUN_LIMIT=5, no halt.
- Response: run high exactly 5 cycles; timeout=1; cyc_count=5; dump strobes high 1 cycle.
REQ-039 Simultaneous events: RUN_LIMIT=4, halt_req asserted on the 4th RUN cycle.
- Response: exit to DUMP; timeout=0; cyc_count=4.
REQ-040 Async reset: RESET_N pulled low between edges during LOAD with LOAD_CYCLES=3.
- Response: read strobes fall without waiting for an edge; state=0; after release, no activity until start.
REQ-041 Ignored inputs:
- start held high through the whole sequence -> no restart before DONE, then immediate re-boot with timeout cleared.
- halt_req=1 in IDLE -> no effect.
REQ-042 Saturation: CW=4, RUN_LIMIT=20.
- Response: cyc_count stops at 15; exit after exactly 20 RUN cycles; timeout=1.

Source files
------------

// File: rtl/boot_sequencer.sv
// Boot sequencer: walks a processor through memory reset, image load, core and
// control-unit reset, a bounded RUN window, image dump, then parks in DONE.
module boot_sequencer #(
  parameter int LOAD_CYCLES = 1,
  parameter int RUN_LIMIT   = 3334,
  parameter int CW          = 16
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          start,
  input  logic          halt_req,
  output logic          im_RESET,
  output logic          dm_RESET,
  output logic          im_read_file,
  output logic          dm_read_file,
  output logic          im_write_file,
  output logic          dm_write_file,
  output logic          pc_RESET,
  output logic          rb_RESET,
  output logic          tf_RESET,
  output logic          rf_RESET,
  output logic          uc_RESET,
  output logic          run,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cyc_count,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MEM_RST  = 3'd1,
    ST_LOAD     = 3'd2,
    ST_CORE_RST = 3'd3,
    ST_UC_RST   = 3'd4,
    ST_RUN      = 3'd5,
    ST_DUMP     = 3'd6,
    ST_DONE     = 3'd7
  } state_e;

  // The watchdog counter is sized from RUN_LIMIT alone, so a narrow, saturating
  // cyc_count never shortens or lengthens the RUN window.
  localparam int             LW        = (RUN_LIMIT > 1) ? $clog2(RUN_LIMIT) : 1;
  localparam logic [LW-1:0]  LIM_LAST  = LW'(RUN_LIMIT - 1);
  localparam logic [7:0]     LOAD_LAST = 8'(LOAD_CYCLES - 1);

  state_e          state_q;
  state_e          state_d;
  logic [7:0]      load_cnt_q;
  logic [LW-1:0]   lim_cnt_q;
  logic [CW-1:0]   cyc_q;
  logic            timeout_q;
  logic            limit_hit;

  assign limit_hit = (RUN_LIMIT != 0) && (lim_cnt_q == LIM_LAST);

  // NOTE: every signal driven here gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (start) state_d = ST_MEM_RST;
      ST_MEM_RST:  state_d = ST_LOAD;
      ST_LOAD:     if (load_cnt_q == 8'd0) state_d = ST_CORE_RST;
      ST_CORE_RST: state_d = ST_UC_RST;
      ST_UC_RST:   state_d = ST_RUN;
      ST_RUN:      if (halt_req || limit_hit) state_d = ST_DUMP;
      ST_DUMP:     state_d = ST_DONE;
      ST_DONE:     if (start) state_d = ST_MEM_RST;
      default:     state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // LOAD length: preset on the MEM_RST cycle, count down to zero inside LOAD.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      load_cnt_q <= 8'd0;
    end else if (state_q == ST_MEM_RST) begin
      load_cnt_q <= LOAD_LAST;
    end else if (state_q == ST_LOAD && load_cnt_q != 8'd0) begin
      load_cnt_q <= load_cnt_q - 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lim_cnt_q <= '0;
    end else if (state_q == ST_UC_RST) begin
      lim_cnt_q <= '0;
    end else if (state_q == ST_RUN && RUN_LIMIT != 0 && lim_cnt_q != LIM_LAST) begin
      lim_cnt_q <= lim_cnt_q + 1'b1;
    end
  end

  // Visible cycle count: cleared on RUN entry, saturates, holds outside RUN.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cyc_q <= '0;
    end else if (state_q == ST_UC_RST) begin
      cyc_q <= '0;
    end else if (state_q == ST_RUN && cyc_q != '1) begin
      cyc_q <= cyc_q + 1'b1;
    end
  end

  // A halt sampled on the same edge as the limit wins, leaving timeout low.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      timeout_q <= 1'b0;
    end else if (state_d == ST_MEM_RST) begin
      timeout_q <= 1'b0;
    end else if (state_q == ST_RUN && !halt_req && limit_hit) begin
      timeout_q <= 1'b1;
    end
  end

  always_comb begin
    im_RESET      = 1'b0;
    dm_RESET      = 1'b0;
    im_read_file  = 1'b0;
    dm_read_file  = 1'b0;
    im_write_file = 1'b0;
    dm_write_file = 1'b0;
    pc_RESET      = 1'b0;
    rb_RESET      = 1'b0;
    tf_RESET      = 1'b0;
    rf_RESET      = 1'b0;
    uc_RESET      = 1'b0;
    unique case (state_q)
      ST_MEM_RST: begin
        im_RESET = 1'b1;
        dm_RESET = 1'b1;
      end
      ST_LOAD: begin
        im_read_file = 1'b1;
        dm_read_file = 1'b1;
      end
      ST_DUMP: begin
        im_write_file = 1'b1;
        dm_write_file = 1'b1;
      end
      default: ;
    endcase
    if (state_q inside {ST_IDLE, ST_MEM_RST, ST_LOAD, ST_CORE_RST}) begin
      pc_RESET = 1'b1;
      rb_RESET = 1'b1;
      tf_RESET = 1'b1;
      rf_RESET = 1'b1;
    end
    if (state_q inside {ST_IDLE, ST_MEM_RST, ST_LOAD, ST_CORE_RST, ST_UC_RST}) begin
      uc_RESET = 1'b1;
    end
  end

  assign run       = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign timeout   = timeout_q;
  assign cyc_count = cyc_q;
  assign state     = state_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Randomized bench: four boot_sequencer configurations run side by side against
// a schedule-based reference model (elapsed time per boot phase).
module tb_boot_sequencer;

  localparam int N = 4;

  function automatic int lc_of(int g);
    case (g)
      0: return 1;
      1: return 3;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int rl_of(int g);
    case (g)
      0: return 0;
      1: return 5;
      2: return 4;
      default: return 20;
    endcase
  endfunction

  function automatic int cw_of(int g);
    return (g == 3) ? 4 : 16;
  endfunction

  localparam int P_IDLE = 0, P_BOOT = 1, P_RUN = 2, P_DUMP = 3, P_DONE = 4;

  typedef struct packed {
    int ph;
    int t;
    int runs;
    bit to;
  } model_t;

  logic CLK = 1'b0;
  logic RESET_N;
  logic start [N];
  logic halt  [N];
  wire  [2:0]  st     [N];
  wire         run_o  [N];
  wire         done_o [N];
  wire         to_o   [N];
  wire  [15:0] cyc    [N];
  wire  [10:0] str    [N];

  model_t m [N];
  int vectors     = 0;
  int miscompares = 0;
  int run_seen [N];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int CWG = cw_of(g);
    logic [CWG-1:0] cnt;
    logic im_r, dm_r, im_rd, dm_rd, im_wr, dm_wr, pc_r, rb_r, tf_r, rf_r, uc_r;
    boot_sequencer #(
      .LOAD_CYCLES(lc_of(g)),
      .RUN_LIMIT  (rl_of(g)),
      .CW         (CWG)
    ) u_dut (
      .CLK          (CLK),
      .RESET_N      (RESET_N),
      .start        (start[g]),
      .halt_req     (halt[g]),
      .im_RESET     (im_r),
      .dm_RESET     (dm_r),
      .im_read_file (im_rd),
      .dm_read_file (dm_rd),
      .im_write_file(im_wr),
      .dm_write_file(dm_wr),
      .pc_RESET     (pc_r),
      .rb_RESET     (rb_r),
      .tf_RESET     (tf_r),
      .rf_RESET     (rf_r),
      .uc_RESET     (uc_r),
      .run          (run_o[g]),
      .done         (done_o[g]),
      .timeout      (to_o[g]),
      .cyc_count    (cnt),
      .state        (st[g])
    );
    assign str[g] = {im_r, dm_r, im_rd, dm_rd, im_wr, dm_wr, pc_r, rb_r, tf_r, rf_r, uc_r};
    assign cyc[g] = 16'(cnt);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic model_t model_reset();
    model_t x;
    x.ph = P_IDLE; x.t = 0; x.runs = 0; x.to = 1'b0;
    return x;
  endfunction

  function automatic model_t step(model_t x, int g, logic s, logic h);
    model_t y = x;
    case (x.ph)
      P_IDLE, P_DONE: if (s) begin y.ph = P_BOOT; y.t = 0; y.to = 1'b0; end
      P_BOOT: begin
        if (x.t == lc_of(g) + 2) begin y.ph = P_RUN; y.runs = 0; end
        else y.t = x.t + 1;
      end
      P_RUN: begin
        y.runs = x.runs + 1;
        if (h) y.ph = P_DUMP;
        else if (rl_of(g) != 0 && y.runs == rl_of(g)) begin y.ph = P_DUMP; y.to = 1'b1; end
      end
      P_DUMP: y.ph = P_DONE;
      default: y.ph = P_IDLE;
    endcase
    return y;
  endfunction

  function automatic int exp_state(model_t x, int g);
    case (x.ph)
      P_IDLE: return 0;
      P_BOOT: begin
        if (x.t == 0) return 1;
        if (x.t <= lc_of(g)) return 2;
        if (x.t == lc_of(g) + 1) return 3;
        return 4;
      end
      P_RUN:  return 5;
      P_DUMP: return 6;
      default: return 7;
    endcase
  endfunction

  function automatic int exp_cyc(model_t x, int g);
    int sat = (1 << cw_of(g)) - 1;
    return (x.runs > sat) ? sat : x.runs;
  endfunction

  function automatic logic [10:0] exp_str(int s);
    return {s == 1, s == 1, s == 2, s == 2, s == 6, s == 6,
            s <= 3, s <= 3, s <= 3, s <= 3, s <= 4};
  endfunction

  task automatic check_all();
    for (int g = 0; g < N; g++) begin
      int es = exp_state(m[g], g);
      check($sformatf("d%0d state", g),   32'(st[g]),     32'(es));
      check($sformatf("d%0d run", g),     32'(run_o[g]),  32'(es == 5));
      check($sformatf("d%0d done", g),    32'(done_o[g]), 32'(es == 7));
      check($sformatf("d%0d timeout", g), 32'(to_o[g]),   32'(m[g].to));
      check($sformatf("d%0d cyc", g),     32'(cyc[g]),    32'(exp_cyc(m[g], g)));
      check($sformatf("d%0d strobes", g), 32'(str[g]),    32'(exp_str(es)));
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RESET_N) begin
      for (int g = 0; g < N; g++) m[g] = step(m[g], g, start[g], halt[g]);
    end
    #1;
    for (int g = 0; g < N; g++) if (run_o[g]) run_seen[g]++;
    check_all();
  endtask

  // Called one time unit after an edge: asserts reset between edges.
  task automatic async_reset(input int low_edges);
    #2 RESET_N = 1'b0;
    #1;
    for (int g = 0; g < N; g++) m[g] = model_reset();
    check_all();
    repeat (low_edges) tick();
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  initial begin
    RESET_N = 1'b0;
    for (int g = 0; g < N; g++) begin
      start[g] = 1'b0;
      halt[g]  = 1'b0;
      m[g]     = model_reset();
      run_seen[g] = 0;
    end
    #3 check_all();
    @(negedge CLK);
    RESET_N = 1'b1;

    // Single start pulse; halts land on RUN cycle 10 (d0) and on the limit cycle (d2).
    for (int g = 0; g < N; g++) start[g] = 1'b1;
    tick();
    for (int g = 0; g < N; g++) start[g] = 1'b0;
    repeat (40) begin
      halt[0] = (m[0].ph == P_RUN && m[0].runs == 9);
      halt[2] = (m[2].ph == P_RUN && m[2].runs == 3);
      tick();
    end
    halt[0] = 1'b0;
    halt[2] = 1'b0;
    check("d0 run cycles", 32'(run_seen[0]), 32'd10);
    check("d1 run cycles", 32'(run_seen[1]), 32'd5);
    check("d2 run cycles", 32'(run_seen[2]), 32'd4);
    check("d3 run cycles", 32'(run_seen[3]), 32'd20);
    check("d0 final cyc", 32'(cyc[0]), 32'd10);
    check("d1 final cyc", 32'(cyc[1]), 32'd5);
    check("d2 final cyc", 32'(cyc[2]), 32'd4);
    check("d3 final cyc", 32'(cyc[3]), 32'd15);
    check("d0 final timeout", 32'(to_o[0]), 32'd0);
    check("d1 final timeout", 32'(to_o[1]), 32'd1);
    check("d2 final timeout", 32'(to_o[2]), 32'd0);
    check("d3 final timeout", 32'(to_o[3]), 32'd1);

    // start held high: no restart before DONE, then immediate re-boot.
    for (int g = 0; g < N; g++) start[g] = 1'b1;
    repeat (60) tick();
    for (int g = 0; g < N; g++) start[g] = 1'b0;

    // Reset in the middle of d1's three-cycle LOAD.
    async_reset(1);
    for (int g = 0; g < N; g++) start[g] = 1'b1;
    tick();
    for (int g = 0; g < N; g++) start[g] = 1'b0;
    tick();
    tick();
    check("d1 in load", 32'(st[1]), 32'd2);
    #2 RESET_N = 1'b0;
    #1;
    for (int g = 0; g < N; g++) m[g] = model_reset();
    check("d1 read strobes drop", 32'(str[1][8:7]), 32'd0);
    check_all();
    repeat (2) tick();
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int g = 0; g < N; g++) halt[g] = 1'b1;
    repeat (6) tick();
    for (int g = 0; g < N; g++) halt[g] = 1'b0;

    // Random traffic with occasional asynchronous resets.
    repeat (2000) begin
      for (int g = 0; g < N; g++) begin
        start[g] = ($urandom_range(0, 7) == 0);
        halt[g]  = ($urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 149) == 0) async_reset($urandom_range(0, 2));
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
